// File: rtl/spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared command codes, FSM state type and a sizing helper
//               for the spi_arbiter code slice.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Command codes understood by spi_controller
  localparam logic [1:0] CMD_SELECT   = 2'b00;
  localparam logic [1:0] CMD_DESELECT = 2'b01;
  localparam logic [1:0] CMD_TRANSFER = 2'b10;

  // Largest supported client count
  localparam int MAX_CLIENTS = 4;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEL_WAIT   = 3'd1,
    ST_GRANTED    = 3'd2,
    ST_XFER_WAIT  = 3'd3,
    ST_DESEL_WAIT = 3'd4
  } spi_arb_state_t;

  // Width of the round-robin pointer for a given client count (2..4)
  function automatic int ptr_width(input int num_clients);
    return (num_clients > 2) ? 2 : 1;
  endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner selection. With SPI_ARB_RR_EN defined
//               the search starts at ptr_i and wraps; otherwise it is a
//               plain priority encoder where the lowest index wins.
//               Configuration macro: SPI_ARB_RR_EN
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import spi_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [PTR_W-1:0]       ptr_i,
  output logic [NUM_CLIENTS-1:0] win_o
);

`ifdef SPI_ARB_RR_EN
  logic [NUM_CLIENTS-1:0] w_mask;
  logic [NUM_CLIENTS-1:0] w_hi;
  logic [NUM_CLIENTS-1:0] w_sel;

  // Mark every client at or above the pointer as eligible for the first pass
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_mask[i] = (PTR_W'(i) >= ptr_i);
    end
  end

  // Requests at/after the pointer win; if none, wrap to the low end
  assign w_hi  = req_i & w_mask;
  assign w_sel = (|w_hi) ? w_hi : req_i;
  assign win_o = w_sel & (~w_sel + NUM_CLIENTS'(1));
`else
  logic w_unused_ptr;

  // Fixed priority: isolate the lowest set request bit
  assign win_o        = req_i & (~req_i + NUM_CLIENTS'(1));
  assign w_unused_ptr = ^ptr_i;
`endif

endmodule : rr_pick
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Shares one spi_controller between NUM_CLIENTS requesters.
//               A granted client gets SELECT, one TRANSFER per offered byte
//               and DESELECT once it drops its request. All outputs are
//               registered.
//               Configuration macro: SPI_ARB_RR_EN (round-robin when defined,
//               fixed lowest-index priority otherwise)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   req_i,
  output logic [NUM_CLIENTS-1:0]   gnt_o,
  input  logic [NUM_CLIENTS-1:0]   tx_valid_i,
  input  logic [8*NUM_CLIENTS-1:0] tx_data_i,
  output logic [NUM_CLIENTS-1:0]   tx_ready_o,
  output logic                     busy_o,
  output logic [1:0]               spi_cmd_o,
  output logic                     spi_start_o,
  output logic [7:0]               spi_data_o,
  input  logic                     spi_ready_i
);

  localparam int PTR_W = ptr_width(NUM_CLIENTS);

  // Registered state and outputs
  spi_arb_state_t         state_q;
  logic [NUM_CLIENTS-1:0] gnt_q;
  logic [NUM_CLIENTS-1:0] tx_ready_q;
  logic                   busy_q;
  logic                   spi_start_q;
  logic [1:0]             spi_cmd_q;
  logic [7:0]             spi_data_q;
  // Set on every command issue: the controller's ready is stale for one cycle
  logic                   skip_q;

  // Combinational helpers
  logic [7:0]             w_data_arr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] w_win;
  logic [PTR_W-1:0]       w_ptr;
  logic                   w_g_valid;
  logic                   w_g_req;
  logic [7:0]             w_g_data;
  logic                   w_arb_fire;

  // Unpack the per-client byte lanes
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slice
    assign w_data_arr[gi] = tx_data_i[8*gi +: 8];
  end

  // Only the granted client's handshake inputs are observed
  assign w_g_valid  = |(tx_valid_i & gnt_q);
  assign w_g_req    = |(req_i & gnt_q);
  assign w_arb_fire = (state_q == ST_IDLE) && (|req_i);

  // Select the granted client's byte (grant is one-hot or zero)
  always_comb begin
    w_g_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_q[i]) begin
        w_g_data = w_g_data | w_data_arr[i];
      end
    end
  end

  rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .PTR_W       (PTR_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (w_ptr),
    .win_o (w_win)
  );

`ifdef SPI_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next search start is the client after the one being granted now
  always_comb begin
    ptr_d = ptr_q;
    if (w_arb_fire) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (w_win[i]) begin
          ptr_d = (i == NUM_CLIENTS - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  // Round-robin pointer register, advanced on each grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign w_ptr = ptr_q;
`else
  assign w_ptr = '0;
`endif

  // Arbitration and command sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      tx_ready_q  <= '0;
      busy_q      <= 1'b0;
      spi_start_q <= 1'b0;
      spi_cmd_q   <= CMD_SELECT;
      spi_data_q  <= '0;
      skip_q      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below
      spi_start_q <= 1'b0;
      tx_ready_q  <= '0;

      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            gnt_q       <= w_win;
            busy_q      <= 1'b1;
            spi_start_q <= 1'b1;
            spi_cmd_q   <= CMD_SELECT;
            skip_q      <= 1'b1;
            state_q     <= ST_SEL_WAIT;
          end
        end

        ST_SEL_WAIT, ST_XFER_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (spi_ready_i) begin
            state_q <= ST_GRANTED;
          end
        end

        ST_GRANTED: begin
          // A pending byte takes precedence over a release in the same cycle
          if (w_g_valid) begin
            spi_data_q  <= w_g_data;
            tx_ready_q  <= gnt_q;
            spi_start_q <= 1'b1;
            spi_cmd_q   <= CMD_TRANSFER;
            skip_q      <= 1'b1;
            state_q     <= ST_XFER_WAIT;
          end else if (!w_g_req) begin
            spi_start_q <= 1'b1;
            spi_cmd_q   <= CMD_DESELECT;
            skip_q      <= 1'b1;
            state_q     <= ST_DESEL_WAIT;
          end
        end

        ST_DESEL_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (spi_ready_i) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          skip_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign tx_ready_o  = tx_ready_q;
  assign busy_o      = busy_q;
  assign spi_cmd_o   = spi_cmd_q;
  assign spi_start_o = spi_start_q;
  assign spi_data_o  = spi_data_q;

endmodule : spi_arbiter
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arbiter
// Description : Self-checking bench for spi_arbiter. Clients replay queued
//               sessions of bytes; a transaction-level model derives the
//               expected command stream and grant order. The controller is a
//               stub that drops spi_ready for 16 cycles after each command.
//               Configuration macro: SPI_ARB_RR_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int N       = 3;
  localparam int TIMEOUT = 8000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   tx_valid = '0;
  logic [8*N-1:0] tx_data = '0;
  logic [N-1:0]   tx_ready;
  logic           busy;
  logic [1:0]     spi_cmd;
  logic           spi_start;
  logic [7:0]     spi_data;
  logic           spi_ready;

  spi_arbiter #(.NUM_CLIENTS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .busy_o      (busy),
    .spi_cmd_o   (spi_cmd),
    .spi_start_o (spi_start),
    .spi_data_o  (spi_data),
    .spi_ready_i (spi_ready)
  );

  always #5 clk = ~clk;

  // Controller stub sharing the arbiter reset
  int stub_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)                 stub_cnt <= 0;
    else if (spi_start)      stub_cnt <= 16;
    else if (stub_cnt != 0)  stub_cnt <= stub_cnt - 1;
  end
  assign spi_ready = (stub_cnt == 0);

  // Bookkeeping
  int n_checks = 0;
  int n_err    = 0;

  // Client-side session queues
  logic [7:0] byte_q [N][$];
  int         len_q  [N][$];
  int         left   [N];
  bit         active [N];
  bit         early  [N];
  logic [N-1:0] prev_gnt = '0;

  // Model-side copies of the same sessions
  logic [7:0] m_bytes [N][$];
  int         m_len   [N][$];
  int         m_ptr   = 0;
  logic [7:0] m_last  = 8'h00;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
    int         cl;
  } exp_t;
  exp_t exp_q[$];

  int age         = 0;
  bit round_first = 1'b1;
  int start_cnt   = 0;
  bit xfer_seen   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue one session of n bytes (taken from the low bytes of b) for client cl
  task automatic add_session(input int cl, input int n, input logic [31:0] b);
    logic [31:0] v;
    v = b;
    len_q[cl].push_back(n);
    m_len[cl].push_back(n);
    for (int k = 0; k < n; k++) begin
      byte_q[cl].push_back(v[7:0]);
      m_bytes[cl].push_back(v[7:0]);
      v = v >> 8;
    end
  endtask

  // Expected command stream: whole sessions, one after another, in grant order
  task automatic build_model();
    int   w;
    int   n;
    bit   any;
    logic [7:0] b;
    forever begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (m_len[i].size() > 0) any = 1'b1;
      if (!any) break;
      w = -1;
`ifdef SPI_ARB_RR_EN
      for (int off = 0; off < N; off++) begin
        if (w < 0 && m_len[(m_ptr + off) % N].size() > 0) w = (m_ptr + off) % N;
      end
      m_ptr = (w + 1) % N;
`else
      for (int i = N - 1; i >= 0; i--) if (m_len[i].size() > 0) w = i;
`endif
      n = m_len[w].pop_front();
      exp_q.push_back('{cmd: CMD_SELECT, data: m_last, cl: w});
      for (int k = 0; k < n; k++) begin
        b = m_bytes[w].pop_front();
        m_last = b;
        exp_q.push_back('{cmd: CMD_TRANSFER, data: b, cl: w});
      end
      exp_q.push_back('{cmd: CMD_DESELECT, data: m_last, cl: w});
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [N-1:0] want_rdy;
    if (spi_start) begin
      start_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.cmd = 2'b11; e.data = 8'h00; e.cl = 0;
      end
      want_rdy = (e.cmd == CMD_TRANSFER) ? N'(1 << e.cl) : '0;
      check_eq("cmd", 32'(spi_cmd), 32'(e.cmd));
      check_eq("data", 32'(spi_data), 32'(e.data));
      check_eq("gnt", 32'(gnt), 32'(1 << e.cl));
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("tx_ready", 32'(tx_ready), 32'(want_rdy));
      check_eq("ctrl_ready_at_start", 32'(spi_ready), 32'd1);
      if (!round_first) check_eq("gap", 32'(age), 32'd2);
      round_first = 1'b0;
      if (spi_cmd == CMD_TRANSFER) xfer_seen = 1'b1;
    end else if (tx_ready != '0) begin
      check_eq("tx_ready_stray", 32'(tx_ready), 32'd0);
    end
    age = spi_ready ? age + 1 : 0;
  endtask

  task automatic clients_update();
    for (int i = 0; i < N; i++) begin
      if (active[i]) begin
        if (tx_ready[i] && left[i] > 0) begin
          void'(byte_q[i].pop_front());
          left[i]--;
        end
        if (prev_gnt[i] && !gnt[i]) begin
          if (len_q[i].size() > 0) left[i] = len_q[i].pop_front();
          else                     active[i] = 1'b0;
        end
      end
    end
    prev_gnt = gnt;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (active[i]) begin
        req[i]      = !(gnt[i] && (left[i] == 0 || (early[i] && left[i] == 1)));
        tx_valid[i] = (left[i] > 0);
        tx_data[8*i +: 8] = (left[i] > 0) ? byte_q[i][0] : 8'($urandom);
      end else begin
        req[i]      = 1'b0;
        tx_valid[i] = 1'($urandom);
        tx_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      monitor();
      clients_update();
    end
    drive();
  endtask

  function automatic bit all_idle();
    bit r;
    r = !busy && (exp_q.size() == 0);
    for (int i = 0; i < N; i++) if (active[i]) r = 1'b0;
    return r;
  endfunction

  task automatic begin_round();
    for (int i = 0; i < N; i++) begin
      if (len_q[i].size() > 0) begin
        active[i] = 1'b1;
        left[i]   = len_q[i].pop_front();
      end
    end
    build_model();
    round_first = 1'b1;
  endtask

  task automatic run_round();
    int cyc;
    begin_round();
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!all_idle() && cyc < TIMEOUT);
    check_eq("round_timeout", 32'(cyc >= TIMEOUT), 32'd0);
    check_eq("expected_left", 32'(exp_q.size()), 32'd0);
    check_eq("idle_gnt", 32'(gnt), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) begin
      early[i] = 1'b0;
      active[i] = 1'b0;
      byte_q[i].delete();
      len_q[i].delete();
    end
    exp_q.delete();
    repeat (2) tick();
  endtask

  initial begin
    int s0;
    int cyc;
    int tot;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; active[i] = 1'b0; early[i] = 1'b0;
    end

    // Reset values
    repeat (3) tick();
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(spi_start), 32'd0);
    check_eq("rst_cmd", 32'(spi_cmd), 32'(CMD_SELECT));
    check_eq("rst_data", 32'(spi_data), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_eq("post_rst_idle_gnt", 32'(gnt), 32'd0);

    // Single client, two bytes
    add_session(0, 2, 32'h0000_CA2E);
    run_round();

    // Contention: client 0 requests twice, client 1 once
    add_session(0, 1, 32'h11);
    add_session(0, 1, 32'h22);
    add_session(1, 1, 32'h33);
    run_round();

    // Release in the same cycle as the final byte offer
    early[0] = 1'b1;
    early[1] = 1'b1;
    add_session(0, 1, 32'h5A);
    add_session(1, 2, 32'h0000_A5C3);
    run_round();

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      tot = 0;
      for (int i = 0; i < N; i++) begin
        int ns;
        ns = $urandom_range(0, 2);
        for (int s = 0; s < ns; s++) begin
          add_session(i, $urandom_range(0, 3), $urandom());
          tot++;
        end
        early[i] = 1'($urandom_range(0, 1));
      end
      if (tot == 0) add_session(0, 1, $urandom());
      run_round();
    end

    // Reset during a byte transfer
    xfer_seen = 1'b0;
    add_session(1, 3, $urandom());
    begin_round();
    cyc = 0;
    while (!xfer_seen && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_eq("xfer_before_rst", 32'(xfer_seen), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      early[i]  = 1'b0;
      byte_q[i].delete();
      len_q[i].delete();
    end
    exp_q.delete();
    prev_gnt = '0;
    m_ptr    = 0;
    m_last   = 8'h00;
    #1;
    check_eq("midrst_gnt", 32'(gnt), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_start", 32'(spi_start), 32'd0);
    check_eq("midrst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("midrst_data", 32'(spi_data), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    s0 = start_cnt;
    repeat (20) tick();
    check_eq("no_cmd_after_rst", 32'(start_cnt - s0), 32'd0);

    // Arbitration state must restart from reset
    add_session(0, 1, 32'h77);
    add_session(1, 1, 32'h88);
    run_round();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule : tb_spi_arbiter
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_controller` between `NUM_CLIENTS` requesters, such as a boot loader and a storage driver. A client requests the bus and receives an exclusive grant. The arbiter then issues SELECT, forwards the client's bytes as TRANSFER commands one at a time, and issues DESELECT when the client releases. Each client sees an ordinary valid/ready byte port, and `spi_controller` sees a single well-formed command stream.

## Interface
- `NUM_CLIENTS`, default 2: number of requesters, 2..4.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `req`  in  NUM_CLIENTS: bus request per client, level.
- `gnt`  out  NUM_CLIENTS: one-hot grant, or zero.
- `tx_valid`  in  NUM_CLIENTS: byte offered by a client.
- `tx_data`  in  8*NUM_CLIENTS: packed bytes, client i at [8i+7:8i].
- `tx_ready`  out  NUM_CLIENTS: one-cycle accept pulse to the granted client.
- `busy`  out  1: high in every state except IDLE.
- `spi_cmd`  out  2: command to the controller.
- `spi_start`  out  1: one-cycle command strobe.
- `spi_data`  out  8: byte to the controller.
- `spi_ready`  in  1: controller idle or done.

## Operation
- Reset values:
  - `gnt`=0, `tx_ready`=0, `busy`=0.
  - `spi_start`=0, `spi_cmd`=CMD_SELECT, `spi_data`=0.
  - Round-robin pointer = 0.
  - State = IDLE.
- IDLE:
  - If any `req` bit is high, pick a winner (see Configuration), register `gnt`, pulse `spi_start` with CMD_SELECT, go to SEL_WAIT.
- SEL_WAIT, XFER_WAIT, DESEL_WAIT:
  - Skip the first cycle after `spi_start`.
  - Then wait for `spi_ready`=1.
  - SEL_WAIT and XFER_WAIT then go to GRANTED; DESEL_WAIT goes to IDLE.
- GRANTED (granted client g):
  - If `tx_valid[g]`: latch `tx_data[g]` into `spi_data`, pulse `tx_ready[g]` and `spi_start` with CMD_TRANSFER in the same cycle, go to XFER_WAIT.
  - Else if `!req[g]`: pulse `spi_start` with CMD_DESELECT, go to DESEL_WAIT.
  - `tx_valid` wins over release in the same cycle.
- `gnt` stays high from IDLE exit until DESEL_WAIT completes, then clears in the same edge that enters IDLE.
- Only one byte is in flight at a time. `spi_data` holds its value until the next TRANSFER.
- Non-granted clients:
  - `tx_ready` never pulses; their `tx_valid` is ignored.
  - `req` may change freely and is re-sampled in IDLE.
- A client that drops `req` while its byte is in flight is released after XFER_WAIT via GRANTED.
- Reset mid-transaction:
  - Returns immediately to the reset values; no DESELECT is issued.
  - `spi_controller` must share the same reset.

## Timing
- Grant latency: `req` high in IDLE gives `gnt` and `spi_start` on the next edge.
- Byte latency: `tx_ready` and `spi_start` are asserted one cycle after entering GRANTED with `tx_valid` high.
- Back-to-back gap: minimum 1 GRANTED cycle between `spi_ready` return and the next `spi_start`.
- Re-arbitration: 1 IDLE cycle between releasing one client and granting the next.
- All outputs are registered.

## Configuration
- `SPI_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - Search starts at client (last granted + 1) mod NUM_CLIENTS.
  - The pointer updates on each grant.
- Undefined:
  - Fixed priority, lowest index wins.
  - No pointer register.

## Structure
- Package `spi_pkg`:
  - `CMD_SELECT`=2'b00, `CMD_DESELECT`=2'b01, `CMD_TRANSFER`=2'b10.
  - State enum `spi_arb_state_t`.
- Sub-module `rr_pick`:
  - Inputs `req` and pointer; output a one-hot winner.
  - Combinational.
  - Degenerates to a priority encoder when `SPI_ARB_RR_EN` is off.
- Model the controller in the bench with a stub: `spi_ready` low for 16 cycles after each `spi_start`.

## Test plan
- Single client:
  - Stimulus: `req`=01; bytes 0x2E and 0xCA; then `req` drops.
  - Expected `spi_cmd` sequence: 00, 10 (data 0x2E), 10 (data 0xCA), 01.
  - Expected: `gnt`=01 throughout, 0 after DESEL_WAIT.
- Contention with `SPI_ARB_RR_EN` defined:
  - Stimulus: `req`=11 held for two transactions.
  - Expected: client 0 granted, then client 1, never 0 twice in a row.
- Contention without `SPI_ARB_RR_EN`:
  - Stimulus: `req`=11 held for two transactions.
  - Expected: client 0 granted both times.
- Simultaneous `tx_valid` and `req` drop in GRANTED:
  - Expected: byte transferred first, then DESELECT.
- Ignored client:
  - Stimulus: `tx_valid[1]`=1 while `gnt`=01.
  - Expected: `tx_ready[1]` stays 0; `spi_data` unchanged.
- Mid-transfer reset:
  - Stimulus: `rst` pulsed during XFER_WAIT.
  - Expected: next cycle `gnt`=0, `busy`=0, `spi_start`=0, no spurious command.
